// File: rtl/scpu_vga_pkg.sv
// scpu_vga_pkg: opcodes, screen limits and plotter state encoding shared by the VGA plotter
package scpu_vga_pkg;
    localparam logic [1:0] OP_PIXEL = 2'b00;
    localparam logic [1:0] OP_HLINE = 2'b01;
    localparam logic [1:0] OP_RECT  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;
    localparam int X_MAX = 159;
    localparam int Y_MAX = 119;
    typedef enum logic [1:0] {IDLE, DRAW, FIN} state_e;
endpackage

// File: rtl/vga_raster_cnt.sv
// vga_raster_cnt: x-inner / y-outer raster counter over a clipped window, last flag at (x_end, y_end)
module vga_raster_cnt
    import scpu_vga_pkg::*;
#(
    parameter int XW = 8,
    parameter int YW = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic          step_i,
    input  logic [XW-1:0] x0_i,
    input  logic [YW-1:0] y0_i,
    input  logic [XW-1:0] x_end_i,
    input  logic [YW-1:0] y_end_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          last_o
);
    logic [XW-1:0] x_q, x_d, x0_q, x0_d, xe_q, xe_d;
    logic [YW-1:0] y_q, y_d, ye_q, ye_d;
    logic          row_end;

    assign row_end = x_q == xe_q;
    assign last_o  = row_end && y_q == ye_q;
    assign x_o     = x_q;
    assign y_o     = y_q;

    // latch the window on load, otherwise advance one pixel per step wrapping x back to x0
    always_comb begin
        x0_d = load_i ? x0_i : x0_q;
        xe_d = load_i ? x_end_i : xe_q;
        ye_d = load_i ? y_end_i : ye_q;
        x_d  = load_i ? x0_i : step_i ? (row_end ? x0_q : x_q + XW'(1)) : x_q;
        y_d  = load_i ? y0_i : (step_i && row_end) ? y_q + YW'(1) : y_q;
    end

    // counter and window registers
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q  <= '0;
            y_q  <= '0;
            x0_q <= '0;
            xe_q <= '0;
            ye_q <= '0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            x0_q <= x0_d;
            xe_q <= xe_d;
            ye_q <= ye_d;
        end
    end
endmodule

// File: rtl/vga_plotter.sv
// vga_plotter: rasterises pixel/hline/rect/clear commands into one framebuffer write per clock; `VGA_PLOT_STALL_EN adds plot_stall
module vga_plotter
    import scpu_vga_pkg::*;
#(
    parameter int XW    = 8,
    parameter int YW    = 7,
    parameter int CW    = 3,
    parameter int X_MAX = scpu_vga_pkg::X_MAX,
    parameter int Y_MAX = scpu_vga_pkg::Y_MAX
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [XW-1:0] cmd_x0,
    input  logic [YW-1:0] cmd_y0,
    input  logic [XW-1:0] cmd_w,
    input  logic [YW-1:0] cmd_h,
    input  logic [CW-1:0] cmd_colour,
`ifdef VGA_PLOT_STALL_EN
    input  logic          plot_stall,
`endif
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [CW-1:0] colour,
    output logic          plot,
    output logic          busy,
    output logic          done
);
    localparam logic [XW-1:0] XM = XW'(X_MAX);
    localparam logic [YW-1:0] YM = YW'(Y_MAX);

    state_e        state_q, state_d;
    logic          pv_q, pv_d;
    logic [CW-1:0] colour_q, colour_d;
    logic [XW-1:0] ex0, x_end;
    logic [YW-1:0] ey0, y_end;
    logic [XW:0]   ew, x_sum;
    logic [YW:0]   eh, y_sum;
    logic          accept, empty, stall, fire, load, step, last;

`ifdef VGA_PLOT_STALL_EN
    assign stall = plot_stall;
`else
    assign stall = 1'b0;
`endif

    assign cmd_ready = state_q == IDLE;
    assign busy      = state_q == DRAW;
    assign done      = state_q == FIN;
    assign accept    = cmd_valid && cmd_ready;
    assign plot      = pv_q && !stall;
    assign fire      = plot;
    assign colour    = colour_q;

    // normalise each opcode to an origin and extent, then clip; sums are one bit wider so nothing wraps
    always_comb begin
        ex0   = cmd_op == OP_CLEAR ? '0 : cmd_x0;
        ey0   = cmd_op == OP_CLEAR ? '0 : cmd_y0;
        ew    = cmd_op == OP_PIXEL ? (XW+1)'(1) : cmd_op == OP_CLEAR ? (XW+1)'(X_MAX + 1) : {1'b0, cmd_w};
        eh    = (cmd_op == OP_PIXEL || cmd_op == OP_HLINE) ? (YW+1)'(1) :
                cmd_op == OP_CLEAR ? (YW+1)'(Y_MAX + 1) : {1'b0, cmd_h};
        x_sum = {1'b0, ex0} + ew - (XW+1)'(1);
        y_sum = {1'b0, ey0} + eh - (YW+1)'(1);
        x_end = x_sum > {1'b0, XM} ? XM : x_sum[XW-1:0];
        y_end = y_sum > {1'b0, YM} ? YM : y_sum[YW-1:0];
        empty = ew == '0 || eh == '0 || ex0 > XM || ey0 > YM;
    end

    // command FSM: the first DRAW cycle only fills the pixel register, so plots start one cycle later
    always_comb begin
        state_d  = state_q;
        pv_d     = pv_q;
        colour_d = colour_q;
        load     = 1'b0;
        step     = 1'b0;
        case (state_q)
            IDLE: begin
                pv_d = 1'b0;
                if (accept) begin
                    colour_d = cmd_colour;
                    load     = !empty;
                    state_d  = empty ? FIN : DRAW;
                end
            end
            DRAW: begin
                pv_d    = !(fire && last);
                step    = fire && !last;
                state_d = (fire && last) ? FIN : DRAW;
            end
            FIN: begin
                pv_d    = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pv_q     <= 1'b0;
            colour_q <= '0;
        end else begin
            state_q  <= state_d;
            pv_q     <= pv_d;
            colour_q <= colour_d;
        end
    end

    vga_raster_cnt #(.XW(XW), .YW(YW)) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load),
        .step_i  (step),
        .x0_i    (ex0),
        .y0_i    (ey0),
        .x_end_i (x_end),
        .y_end_i (y_end),
        .x_o     (x),
        .y_o     (y),
        .last_o  (last)
    );
endmodule

// File: tb/tb_vga_plotter.sv
// tb_vga_plotter: randomized and directed checks of vga_plotter against a per-cycle schedule model
module tb_vga_plotter;
    typedef struct packed {
        logic       plot;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       busy;
        logic       done;
        logic       ready;
    } cyc_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = '0;
    logic [7:0] cmd_x0 = '0;
    logic [6:0] cmd_y0 = '0;
    logic [7:0] cmd_w = '0;
    logic [6:0] cmd_h = '0;
    logic [2:0] cmd_colour = '0;
    logic       plot_stall = 1'b0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, done;

    int   tests = 0;
    int   fails = 0;
    int   acc_cnt = 0;
    int   plot_cnt = 0;
    int   done_cnt = 0;
    logic armed = 1'b0;
    logic en = 1'b1;
    cyc_t exp_q[$];

    vga_plotter dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_x0     (cmd_x0),
        .cmd_y0     (cmd_y0),
        .cmd_w      (cmd_w),
        .cmd_h      (cmd_h),
        .cmd_colour (cmd_colour),
`ifdef VGA_PLOT_STALL_EN
        .plot_stall (plot_stall),
`endif
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
        end
    endfunction

    function automatic cyc_t exp_now();
        cyc_t r;
        r = '{plot: 1'b0, x: 8'd0, y: 7'd0, c: 3'd0, busy: 1'b0, done: 1'b0, ready: 1'b1};
        if (exp_q.size() > 0) r = exp_q[0];
        return r;
    endfunction

    // expected cycles after an accept: one fill cycle, the clipped raster, then one done cycle
    task automatic push_cmd();
        int x0, y0, w, h, xe, ye;
        cyc_t r;
        x0 = cmd_op == 2'd3 ? 0 : int'(cmd_x0);
        y0 = cmd_op == 2'd3 ? 0 : int'(cmd_y0);
        w  = cmd_op == 2'd0 ? 1 : cmd_op == 2'd3 ? 160 : int'(cmd_w);
        h  = cmd_op <= 2'd1 ? 1 : cmd_op == 2'd3 ? 120 : int'(cmd_h);
        xe = (x0 + w - 1 < 159) ? x0 + w - 1 : 159;
        ye = (y0 + h - 1 < 119) ? y0 + h - 1 : 119;
        if (w > 0 && h > 0 && x0 <= 159 && y0 <= 119) begin
            r = '{plot: 1'b0, x: 8'd0, y: 7'd0, c: 3'd0, busy: 1'b1, done: 1'b0, ready: 1'b0};
            exp_q.push_back(r);
            for (int yy = y0; yy <= ye; yy++)
                for (int xx = x0; xx <= xe; xx++) begin
                    r = '{plot: 1'b1, x: 8'(xx), y: 7'(yy), c: cmd_colour, busy: 1'b1, done: 1'b0, ready: 1'b0};
                    exp_q.push_back(r);
                end
        end
        r = '{plot: 1'b0, x: 8'd0, y: 7'd0, c: 3'd0, busy: 1'b0, done: 1'b1, ready: 1'b0};
        exp_q.push_back(r);
    endtask

    // model: an empty schedule means idle and ready; advance one cycle per clock
    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            armed <= 1'b1;
        end else if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
        end else if (cmd_valid) begin
            acc_cnt <= acc_cnt + 1;
            push_cmd();
        end
    end

    // compare DUT against the model every cycle, away from the clock edge
    always @(negedge clk) begin
        if (armed && en) begin
            chk("plot", plot, exp_now().plot);
            chk("busy", busy, exp_now().busy);
            chk("done", done, exp_now().done);
            chk("cmd_ready", cmd_ready, exp_now().ready);
            if (exp_now().plot) begin
                chk("x", x, exp_now().x);
                chk("y", y, exp_now().y);
                chk("colour", colour, exp_now().c);
            end
        end
        plot_cnt <= plot_cnt + (plot ? 1 : 0);
        done_cnt <= done_cnt + (done ? 1 : 0);
    end

    task automatic issue(input int op, input int x0, input int y0, input int w, input int h, input int c);
        int a, t;
        a = acc_cnt;
        t = 0;
        cmd_op = 2'(op);
        cmd_x0 = 8'(x0);
        cmd_y0 = 7'(y0);
        cmd_w = 8'(w);
        cmd_h = 7'(h);
        cmd_colour = 3'(c);
        cmd_valid = 1'b1;
        while (acc_cnt == a && t < 25000) begin
            @(negedge clk);
            t++;
        end
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom);
        cmd_x0 = 8'($urandom);
        cmd_y0 = 7'($urandom);
        cmd_w = 8'($urandom);
        cmd_h = 7'($urandom);
        cmd_colour = 3'($urandom);
        chk("accept", acc_cnt - a, 1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 25000) begin
            @(negedge clk);
            t++;
        end
        chk("drain", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int xs[6] = '{4, 5, 6, 4, 5, 6};
        int ys[6] = '{2, 2, 2, 3, 3, 3};
        int pc, dc;
        repeat (3) @(negedge clk);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_colour", colour, 0);
        chk("rst_plot", plot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cmd_ready, 1);
        reset = 1'b0;
        @(negedge clk);

        issue(0, 10, 20, 0, 0, 5);
        chk("px_fill_plot", plot, 0);
        @(negedge clk);
        chk("px_plot", plot, 1);
        chk("px_x", x, 10);
        chk("px_y", y, 20);
        chk("px_colour", colour, 5);
        @(negedge clk);
        chk("px_done", done, 1);
        chk("px_noplot", plot, 0);
        drain();

        issue(2, 4, 2, 3, 2, 3);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rect_plot", plot, 1);
            chk("rect_x", x, xs[i]);
            chk("rect_y", y, ys[i]);
        end
        @(negedge clk);
        chk("rect_done", done, 1);
        drain();

        issue(1, 158, 9, 10, 0, 4);
        @(negedge clk);
        chk("hl_x0", x, 158);
        chk("hl_y0", y, 9);
        @(negedge clk);
        chk("hl_x1", x, 159);
        chk("hl_plot1", plot, 1);
        @(negedge clk);
        chk("hl_end_plot", plot, 0);
        chk("hl_done", done, 1);
        drain();

        pc = plot_cnt;
        dc = done_cnt;
        issue(3, 77, 33, 9, 9, 0);
        drain();
        chk("clear_plots", plot_cnt - pc, 19200);
        chk("clear_done", done_cnt - dc, 1);

        pc = plot_cnt;
        dc = done_cnt;
        issue(2, 200, 5, 4, 4, 1);
        drain();
        issue(2, 10, 5, 0, 4, 1);
        drain();
        issue(2, 5, 125, 3, 3, 1);
        drain();
        chk("zero_plots", plot_cnt - pc, 0);
        chk("zero_done", done_cnt - dc, 3);

        issue(2, 30, 30, 10, 10, 2);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_plot", plot, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_ready", cmd_ready, 1);
        reset = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            issue($urandom_range(0, 2), $urandom_range(0, 175), $urandom_range(0, 127),
                  $urandom_range(0, 20), $urandom_range(0, 12), $urandom_range(0, 7));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();

`ifdef VGA_PLOT_STALL_EN
        begin
            int got;
            got = 0;
            en = 1'b0;
            issue(1, 20, 5, 4, 0, 6);
            for (int k = 0; k < 16; k++) begin
                @(negedge clk);
                plot_stall = (k >= 1 && k <= 3);
                #1;
                if (plot_stall) chk("stall_plot", plot, 0);
                if (plot) begin
                    chk("stall_x", x, 20 + got);
                    chk("stall_y", y, 5);
                    got++;
                end
            end
            plot_stall = 1'b0;
            chk("stall_count", got, 4);
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            en = 1'b1;
            @(negedge clk);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
